mem_access_unit: RTL

Load/store sequencer sitting directly upstream of the word-addressed data memory in the MIPS datapath. It accepts byte-addressed load/store requests of byte, halfword or word size from the execute stage and drives the memory's read/write strobes, word address and write data. Sub-word stores are performed as read-modify-write. Load results are returned lane-extracted and sign- or zero-extended, with a one-cycle response pulse.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states
// and the big-endian lane position helper.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Big-endian: offset 0 is the most significant lane, so the shift shrinks as offset grows.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {~off, 3'b000};
            SZ_HALF: return {~off[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension
// and sub-word store merge into an existing memory word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> lane_shift(off, size);
        case (size)
            SZ_BYTE: return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh = lane_shift(off, size);
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << sh;
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    assign ld_data_o = load_extract(rd_word_i, off_i, size_i, uns_i);
    assign st_word_o = store_merge(rd_word_i, st_data_i, off_i, size_i);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-addressed data memory; sub-word
// stores are done as read-modify-write, every output is registered.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read_signal,
    output logic        mem_write_signal,
    input  logic [31:0] mem_read_data
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mwd_q, mwd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_q, rvld_q, rd_q, wrs_q;
    logic        req_err;
    logic [31:0] ld_data, st_word;

    assign req_err = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    mem_lane_align u_align (
        .rd_word_i (mem_read_data),
        .off_i     (off_q),
        .size_i    (size_q),
        .uns_i     (uns_q),
        .st_data_i (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        mwd_d   = mwd_q;
        rdata_d = 32'h0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        addr_d = {2'b00, req_addr[31:2]};
                        if (req_write && req_size == SZ_WORD) begin
                            state_d = ST_WRITE;
                            mwd_d   = req_wdata;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (wr_q) begin
                    mwd_d   = st_word;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = ld_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            rvld_q  <= 1'b0;
            rd_q    <= 1'b0;
            wrs_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            mwd_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            rvld_q  <= (state_d == ST_RESP);
            rd_q    <= (state_d == ST_READ);
            wrs_q   <= (state_d == ST_WRITE);
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            mwd_q   <= mwd_d;
        end
    end

    // Latched request fields are only consumed while a request is in flight.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        size_q  <= size_d;
        off_q   <= off_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
    end

    assign req_ready        = ready_q;
    assign resp_valid       = rvld_q;
    assign resp_rdata       = rdata_q;
    assign resp_error       = err_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = mwd_q;
    assign mem_read_signal  = rd_q;
    assign mem_write_signal = wrs_q;

endmodule
